// File: rtl/dzmcu_bus_ctrl.sv
// MCU bus memory controller: serves boot ROM, HRAM and the boot-disable register locally and forwards other accesses to an external req/ack port.
// Optional external-port timeout is built in when DZMCU_BUS_TIMEOUT_EN is defined.
module dzmcu_bus_ctrl #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int BOOT_SIZE_LOG2 = 8
) (
   input  logic                      iClock,
   input  logic                      iReset,
   input  logic [15:0]               iCpuAddr,
   input  logic [7:0]                iCpuData,
   input  logic                      iCpuWe,
   input  logic                      iCpuReadRequest,
   output logic [7:0]                oCpuData,
   output logic                      oAck,
   output logic                      oBusy,
   output logic [BOOT_SIZE_LOG2-1:0] oBootAddr,
   input  logic [7:0]                iBootData,
   output logic                      oBootEnabled,
   output logic [15:0]               oExtAddr,
   output logic [7:0]                oExtData,
   output logic                      oExtWe,
   output logic                      oExtReq,
   input  logic                      iExtAck,
   input  logic [7:0]                iExtData,
   output logic                      oBusError,
   output logic [1:0]                oDbgState
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOCAL, ST_EXT_WAIT, ST_ACK} state_t;

   localparam logic [16:0] BOOT_LIMIT = 17'(1) << BOOT_SIZE_LOG2;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 2..255");
   end

   state_t      r_state, w_next_state;
   logic [15:0] r_addr;
   logic [7:0]  r_wdata;
   logic        r_we;
   logic [7:0]  r_cpu_data;
   logic        r_boot_en;
   logic [7:0]  r_hram [0:126];

   logic        w_strobe, w_req_local, w_lat_boot, w_lat_bdis, w_lat_hram, w_timeout;
   logic [6:0]  w_hram_idx;

   assign w_strobe    = iCpuWe | iCpuReadRequest;
   // Writes into the boot window are MBC register writes and always go external.
   assign w_req_local = (({1'b0, iCpuAddr} < BOOT_LIMIT) && r_boot_en && !iCpuWe) ||
                        (iCpuAddr == 16'hFF50) ||
                        (iCpuAddr >= 16'hFF80 && iCpuAddr != 16'hFFFF);
   assign w_lat_boot  = ({1'b0, r_addr} < BOOT_LIMIT) && r_boot_en && !r_we;
   assign w_lat_bdis  = (r_addr == 16'hFF50);
   assign w_lat_hram  = (r_addr >= 16'hFF80) && (r_addr != 16'hFFFF);
   assign w_hram_idx  = r_addr[6:0];

`ifdef DZMCU_BUS_TIMEOUT_EN
   logic [7:0] r_tmo_cnt;
   logic       r_bus_err;

   assign w_timeout = (r_state == ST_EXT_WAIT) && !iExtAck &&
                      (r_tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge iClock) begin
      if (!iReset || r_state != ST_EXT_WAIT) r_tmo_cnt <= 8'd0;
      else                                    r_tmo_cnt <= r_tmo_cnt + 8'd1;
   end

   always_ff @(posedge iClock) begin
      if (!iReset)        r_bus_err <= 1'b0;
      else if (w_timeout) r_bus_err <= 1'b1;
   end

   assign oBusError = r_bus_err;
`else
   assign w_timeout = 1'b0;
   assign oBusError = 1'b0;
`endif

   always_ff @(posedge iClock) begin
      if (!iReset) r_state <= ST_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:     if (w_strobe) w_next_state = w_req_local ? ST_LOCAL : ST_EXT_WAIT;
         ST_LOCAL:    w_next_state = ST_ACK;
         ST_EXT_WAIT: if (iExtAck || w_timeout) w_next_state = ST_ACK;
         ST_ACK:      w_next_state = ST_IDLE;
         default:     w_next_state = ST_IDLE;
      endcase
   end

   // External port: oExtReq rises on entry to EXT_WAIT and stays high, with address/data/we
   // frozen, until the first cycle iExtAck is sampled high; iExtAck at any other time is ignored.
   always_comb begin
      oAck    = (r_state == ST_ACK);
      oBusy   = (r_state != ST_IDLE);
      oExtReq = (r_state == ST_EXT_WAIT);
      oExtWe  = (r_state == ST_EXT_WAIT) && r_we;
   end

   always_ff @(posedge iClock) begin
      if (!iReset) begin
         r_addr     <= 16'h0000;
         r_wdata    <= 8'h00;
         r_we       <= 1'b0;
         r_cpu_data <= 8'h00;
         r_boot_en  <= 1'b1;
      end else begin
         if (r_state == ST_IDLE && w_strobe) begin
            r_addr  <= iCpuAddr;
            r_wdata <= iCpuData;
            r_we    <= iCpuWe;
         end
         if (r_state == ST_LOCAL) begin
            if (w_lat_hram) begin
               if (!r_we) r_cpu_data <= r_hram[w_hram_idx];
            end else if (w_lat_bdis) begin
               if (r_we) begin
                  if (r_wdata != 8'h00) r_boot_en <= 1'b0;
               end else begin
                  r_cpu_data <= {7'b1111111, ~r_boot_en};
               end
            end else if (w_lat_boot) begin
               r_cpu_data <= iBootData;
            end
         end
         if (r_state == ST_EXT_WAIT && !r_we) begin
            if (iExtAck)        r_cpu_data <= iExtData;
            else if (w_timeout) r_cpu_data <= 8'hFF;
         end
      end
   end

   always_ff @(posedge iClock) begin
      if (iReset && r_state == ST_LOCAL && w_lat_hram && r_we) r_hram[w_hram_idx] <= r_wdata;
   end

   assign oCpuData     = r_cpu_data;
   assign oBootAddr    = r_addr[BOOT_SIZE_LOG2-1:0];
   assign oBootEnabled = r_boot_en;
   assign oExtAddr     = r_addr;
   assign oExtData     = r_wdata;
   assign oDbgState    = r_state;

endmodule

// File: tb/tb_dzmcu_bus_ctrl.sv
// Directed bench for dzmcu_bus_ctrl: table of single accesses plus hand-written busy, reset and timeout sequences.
module tb_dzmcu_bus_ctrl;

   logic        clk;
   logic        rst_n;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we;
   logic        cpu_rd;
   logic [7:0]  cpu_rdata;
   logic        ack;
   logic        busy;
   logic [7:0]  boot_addr;
   logic [7:0]  boot_data;
   logic        boot_en;
   logic [15:0] ext_addr;
   logic [7:0]  ext_wdata;
   logic        ext_we;
   logic        ext_req;
   logic        ext_ack;
   logic [7:0]  ext_rdata;
   logic        bus_err;
   logic [1:0]  dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];

   dzmcu_bus_ctrl #(.TIMEOUT_CYCLES(8), .BOOT_SIZE_LOG2(8)) dut (
      .iClock(clk), .iReset(rst_n),
      .iCpuAddr(cpu_addr), .iCpuData(cpu_wdata), .iCpuWe(cpu_we), .iCpuReadRequest(cpu_rd),
      .oCpuData(cpu_rdata), .oAck(ack), .oBusy(busy),
      .oBootAddr(boot_addr), .iBootData(boot_data), .oBootEnabled(boot_en),
      .oExtAddr(ext_addr), .oExtData(ext_wdata), .oExtWe(ext_we), .oExtReq(ext_req),
      .iExtAck(ext_ack), .iExtData(ext_rdata), .oBusError(bus_err), .oDbgState(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver: one CPU access, with an external responder acking on the ext_delay-th EXT_WAIT cycle
   // (ext_delay 0 = never ack). Outputs sampled on negedge.
   task automatic do_access(input logic [15:0] addr, input logic [7:0] wdata, input bit we,
                            input logic [7:0] bdata, input int ext_delay, input logic [7:0] edata,
                            output int lat, output int req_cyc, output int acks, output bit addr_ok,
                            output bit we_ok, output logic [7:0] rdata, output logic [7:0] baddr);
      @(negedge clk);
      cpu_addr = addr; cpu_wdata = wdata; cpu_we = we; cpu_rd = !we; boot_data = bdata;
      @(negedge clk);
      cpu_we = 1'b0; cpu_rd = 1'b0;
      lat = 0; req_cyc = 0; acks = 0; addr_ok = 1'b1; we_ok = 1'b1; rdata = 8'h00; baddr = 8'h00;
      for (int n = 1; n <= 80; n++) begin
         if (ext_req) begin
            req_cyc++;
            if (ext_addr !== addr) addr_ok = 1'b0;
            if (ext_we !== we || (we && ext_wdata !== wdata)) we_ok = 1'b0;
         end
         if (ext_req && req_cyc == ext_delay) begin
            ext_ack = 1'b1; ext_rdata = edata;
         end else begin
            ext_ack = 1'b0; ext_rdata = 8'h00;
         end
         if (ack) begin
            acks++;
            if (lat == 0) begin
               lat = n; rdata = cpu_rdata; baddr = boot_addr;
            end
         end
         if (lat != 0 && n >= lat + 2) break;
         @(negedge clk);
      end
      ext_ack = 1'b0;
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  wdata;
      bit          we;
      logic [7:0]  bdata;
      int          ext_delay;
      logic [7:0]  edata;
      logic [7:0]  exp_rd;
      bit          chk_boot;
   } vec_t;

   vec_t vecs[20];

   initial begin
      int lat, req_cyc, acks, exp_lat, cnt;
      bit addr_ok, we_ok;
      logic [7:0] rdata, baddr, exp_rd;

      // exp_rd on writes is the value oCpuData must keep holding
      vecs[0]  = '{16'hFF90, 8'h5A, 1'b1, 8'h00, 0, 8'h00, 8'h00, 1'b0};
      vecs[1]  = '{16'hFF90, 8'h00, 1'b0, 8'h00, 0, 8'h00, 8'h5A, 1'b0};
      vecs[2]  = '{16'hFF80, 8'h11, 1'b1, 8'h00, 0, 8'h00, 8'h5A, 1'b0};
      vecs[3]  = '{16'hFFFE, 8'hEE, 1'b1, 8'h00, 0, 8'h00, 8'h5A, 1'b0};
      vecs[4]  = '{16'hFF80, 8'h00, 1'b0, 8'h00, 0, 8'h00, 8'h11, 1'b0};
      vecs[5]  = '{16'hFFFE, 8'h00, 1'b0, 8'h00, 0, 8'h00, 8'hEE, 1'b0};
      vecs[6]  = '{16'h0010, 8'h00, 1'b0, 8'h31, 0, 8'h00, 8'h31, 1'b1};
      vecs[7]  = '{16'hFF50, 8'h00, 1'b0, 8'h00, 0, 8'h00, 8'hFE, 1'b0};
      vecs[8]  = '{16'h0010, 8'h77, 1'b1, 8'h00, 1, 8'h00, 8'hFE, 1'b0};
      vecs[9]  = '{16'hFF50, 8'h00, 1'b1, 8'h00, 0, 8'h00, 8'hFE, 1'b0};
      vecs[10] = '{16'hFF50, 8'h00, 1'b0, 8'h00, 0, 8'h00, 8'hFE, 1'b0};
      vecs[11] = '{16'h00FF, 8'h00, 1'b0, 8'h9C, 0, 8'h00, 8'h9C, 1'b1};
      vecs[12] = '{16'h0100, 8'h00, 1'b0, 8'h00, 2, 8'h42, 8'h42, 1'b0};
      vecs[13] = '{16'hFF50, 8'h01, 1'b1, 8'h00, 0, 8'h00, 8'h42, 1'b0};
      vecs[14] = '{16'hFF50, 8'h00, 1'b0, 8'h00, 0, 8'h00, 8'hFF, 1'b0};
      vecs[15] = '{16'h0010, 8'h00, 1'b0, 8'h31, 1, 8'h5C, 8'h5C, 1'b0};
      vecs[16] = '{16'hFFFF, 8'h00, 1'b0, 8'h00, 3, 8'h81, 8'h81, 1'b0};
      vecs[17] = '{16'hFF90, 8'h00, 1'b0, 8'h00, 0, 8'h00, 8'h5A, 1'b0};
      vecs[18] = '{16'h8000, 8'h00, 1'b0, 8'h00, 4, 8'hC3, 8'hC3, 1'b0};
      vecs[19] = '{16'hC000, 8'hA5, 1'b1, 8'h00, 2, 8'h00, 8'hC3, 1'b0};

      rst_n = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_we = 1'b0; cpu_rd = 1'b0;
      boot_data = 8'h00; ext_ack = 1'b0; ext_rdata = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_cpu_data", cpu_rdata, 8'h00);
      check("reset_ack", ack, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_ext_req", ext_req, 1'b0);
      check("reset_ext_we", ext_we, 1'b0);
      check("reset_ext_addr", ext_addr, 16'h0000);
      check("reset_ext_data", ext_wdata, 8'h00);
      check("reset_boot_addr", boot_addr, 8'h00);
      check("reset_boot_en", boot_en, 1'b1);
      check("reset_bus_err", bus_err, 1'b0);

      for (int i = 0; i < 20; i++) begin
         exp_q.push_back(vecs[i].exp_rd);
         do_access(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].bdata, vecs[i].ext_delay,
                   vecs[i].edata, lat, req_cyc, acks, addr_ok, we_ok, rdata, baddr);
         exp_lat = (vecs[i].ext_delay == 0) ? 2 : vecs[i].ext_delay + 1;
         exp_rd  = exp_q.pop_front();
         check($sformatf("vec%0d_latency", i), lat, exp_lat);
         check($sformatf("vec%0d_ack_count", i), acks, 1);
         check($sformatf("vec%0d_ext_req_cycles", i), req_cyc, vecs[i].ext_delay);
         check($sformatf("vec%0d_cpu_data", i), rdata, exp_rd);
         if (vecs[i].ext_delay != 0) begin
            check($sformatf("vec%0d_ext_addr_stable", i), addr_ok, 1'b1);
            check($sformatf("vec%0d_ext_we_data", i), we_ok, 1'b1);
         end
         if (vecs[i].chk_boot) check($sformatf("vec%0d_boot_addr", i), baddr, vecs[i].addr[7:0]);
      end
      check("boot_disabled", boot_en, 1'b0);

      // strobe while busy must be dropped, not queued
      @(negedge clk);
      cpu_addr = 16'h8000; cpu_rd = 1'b1;
      @(negedge clk);
      cpu_addr = 16'hFF90;
      @(negedge clk);
      cpu_rd = 1'b0;
      check("busy_ext_addr", ext_addr, 16'h8000);
      check("busy_busy", busy, 1'b1);
      ext_ack = 1'b1; ext_rdata = 8'h3C;
      @(negedge clk);
      ext_ack = 1'b0; ext_rdata = 8'h00;
      check("busy_ack", ack, 1'b1);
      check("busy_cpu_data", cpu_rdata, 8'h3C);
      cnt = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (ack || busy) cnt++;
      end
      check("busy_no_queued_access", cnt, 0);

`ifdef DZMCU_BUS_TIMEOUT_EN
      do_access(16'hA000, 8'h00, 1'b0, 8'h00, 0, 8'h00, lat, req_cyc, acks, addr_ok, we_ok, rdata, baddr);
      check("tmo_latency", lat, 9);
      check("tmo_ext_req_cycles", req_cyc, 8);
      check("tmo_ack_count", acks, 1);
      check("tmo_cpu_data", rdata, 8'hFF);
      check("tmo_bus_err", bus_err, 1'b1);
      ext_ack = 1'b1; ext_rdata = 8'h12;
      @(negedge clk);
      ext_ack = 1'b0;
      check("tmo_late_ack_ignored", {ack, busy}, 2'b00);
      do_access(16'hFF90, 8'h00, 1'b0, 8'h00, 0, 8'h00, lat, req_cyc, acks, addr_ok, we_ok, rdata, baddr);
      check("tmo_bus_err_sticky", bus_err, 1'b1);
      check("tmo_after_read", rdata, 8'h5A);
`else
      do_access(16'hA000, 8'h00, 1'b0, 8'h00, 20, 8'h6E, lat, req_cyc, acks, addr_ok, we_ok, rdata, baddr);
      check("wait_latency", lat, 21);
      check("wait_ext_req_cycles", req_cyc, 20);
      check("wait_cpu_data", rdata, 8'h6E);
      check("wait_bus_err", bus_err, 1'b0);
`endif

      // reset in the middle of an external access
      @(negedge clk);
      cpu_addr = 16'hA000; cpu_rd = 1'b1;
      @(negedge clk);
      cpu_rd = 1'b0;
      @(negedge clk);
      check("mid_ext_req", ext_req, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_ext_req", ext_req, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_ack", ack, 1'b0);
      check("mid_rst_boot_en", boot_en, 1'b1);
      check("mid_rst_cpu_data", cpu_rdata, 8'h00);
      check("mid_rst_bus_err", bus_err, 1'b0);
      rst_n = 1'b1;
      ext_ack = 1'b1; ext_rdata = 8'h99;
      @(negedge clk);
      ext_ack = 1'b0;
      cnt = 0;
      for (int n = 0; n < 5; n++) begin
         if (ack || busy) cnt++;
         @(negedge clk);
      end
      check("mid_rst_no_ack", cnt, 0);

      do_access(16'h0010, 8'h00, 1'b0, 8'h31, 0, 8'h00, lat, req_cyc, acks, addr_ok, we_ok, rdata, baddr);
      check("post_rst_boot_latency", lat, 2);
      check("post_rst_boot_ext", req_cyc, 0);
      check("post_rst_boot_data", rdata, 8'h31);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
